// File: rtl/alu_pkg.sv
// Shared opcodes, condition codes, flag positions and FSM encodings for the ALU execute stage.
package alu_pkg;

  typedef enum logic [3:0] {
    OpAnd = 4'h0, OpXor = 4'h1, OpSub = 4'h2, OpRsb = 4'h3, OpAdd = 4'h4,
    OpCmp = 4'h5, OpCmn = 4'h6, OpOrr = 4'h7, OpMov = 4'h8, OpLsl = 4'h9,
    OpLsr = 4'hA, OpBic = 4'hB, OpMvn = 4'hC
  } alu_op_e;

  localparam logic [3:0] CondEq = 4'h0, CondNe = 4'h1, CondCs = 4'h2, CondCc = 4'h3;
  localparam logic [3:0] CondMi = 4'h4, CondPl = 4'h5, CondVs = 4'h6, CondVc = 4'h7;
  localparam logic [3:0] CondHi = 4'h8, CondLs = 4'h9, CondGe = 4'hA, CondLt = 4'hB;
  localparam logic [3:0] CondGt = 4'hC, CondLe = 4'hD, CondAl = 4'hE, CondNv = 4'hF;

  localparam int unsigned FlagN = 3;
  localparam int unsigned FlagZ = 2;
  localparam int unsigned FlagC = 1;
  localparam int unsigned FlagV = 0;

  typedef logic [1:0] state_t;
  localparam state_t StIdle  = 2'd0;
  localparam state_t StShift = 2'd1;
  localparam state_t StDone  = 2'd2;

  // Bits are only written when the condition passed and the mask enables that pair.
  function automatic logic [3:0] upd_flags(input logic [3:0] old, input logic n, input logic z,
                                           input logic c, input logic v,
                                           input logic [1:0] fw, input logic ex);
    logic [3:0] f;
    f = old;
    if (ex && fw[1]) begin
      f[FlagN] = n;
      f[FlagZ] = z;
    end
    if (ex && fw[0]) begin
      f[FlagC] = c;
      f[FlagV] = v;
    end
    return f;
  endfunction

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the decoder, the execute stage and writeback.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
);
  logic               start;
  logic [3:0]         alu_ctrl;
  logic [1:0]         flag_w;
  logic [3:0]         cond;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [SHAMT_W-1:0] shamt;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   result;
  logic               res_we;
  logic [3:0]         flags;

  modport master (
    output start, alu_ctrl, flag_w, cond, a, b, shamt,
    input  busy, done, result, res_we, flags
  );

  modport slave (
    input  start, alu_ctrl, flag_w, cond, a, b, shamt,
    output busy, done, result, res_we, flags
  );
endinterface

// File: rtl/cond_check.sv
// ARM-style condition evaluation against the {N,Z,C,V} flags.
module cond_check
  import alu_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_cond_ex
);
  logic w_n, w_z, w_c, w_v;

  assign w_n = i_flags[FlagN];
  assign w_z = i_flags[FlagZ];
  assign w_c = i_flags[FlagC];
  assign w_v = i_flags[FlagV];

  always_comb begin
    o_cond_ex = 1'b1;
    unique case (i_cond)
      CondEq:  o_cond_ex = w_z;
      CondNe:  o_cond_ex = !w_z;
      CondCs:  o_cond_ex = w_c;
      CondCc:  o_cond_ex = !w_c;
      CondMi:  o_cond_ex = w_n;
      CondPl:  o_cond_ex = !w_n;
      CondVs:  o_cond_ex = w_v;
      CondVc:  o_cond_ex = !w_v;
      CondHi:  o_cond_ex = w_c && !w_z;
      CondLs:  o_cond_ex = !w_c || w_z;
      CondGe:  o_cond_ex = (w_n == w_v);
      CondLt:  o_cond_ex = (w_n != w_v);
      CondGt:  o_cond_ex = !w_z && (w_n == w_v);
      CondLe:  o_cond_ex = w_z || (w_n != w_v);
      default: o_cond_ex = 1'b1;
    endcase
  end
endmodule

// File: rtl/alu_exec_unit.sv
// ALU execute stage: single-cycle logic/arithmetic ops, bit-serial shifts, NZCV flag register.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_exec_unit_if.slave  bus
);
  state_t             r_state, w_state_d;
  logic [3:0]         r_op, w_op_d;
  logic [1:0]         r_fw, w_fw_d;
  logic               r_cond_ex, w_cond_ex_d;
  logic [WIDTH-1:0]   r_acc, w_acc_d;
  logic [SHAMT_W-1:0] r_cnt, w_cnt_d;
  logic [WIDTH-1:0]   r_result, w_result_d;
  logic [3:0]         r_flags, w_flags_d;
  logic               r_res_we, w_res_we_d;

  logic               w_cond_ex;
  logic               w_is_shift;
  logic [WIDTH-1:0]   w_x, w_y, w_res, w_shift_res;
  logic               w_cin, w_c, w_v, w_ovf;
  logic [WIDTH:0]     w_sum;

  cond_check u_cond_check (
    .i_cond    (bus.cond),
    .i_flags   (r_flags),
    .o_cond_ex (w_cond_ex)
  );

  assign w_is_shift = ((bus.alu_ctrl == OpLsl) || (bus.alu_ctrl == OpLsr)) &&
                      (bus.shamt != '0);
  assign w_shift_res = (r_op == OpLsl) ? (r_acc << 1) : (r_acc >> 1);

  // One adder serves ADD/CMN (a+b), SUB/CMP (a+~b+1) and RSB (b+~a+1).
  always_comb begin
    w_x   = bus.a;
    w_y   = bus.b;
    w_cin = 1'b0;
    unique case (bus.alu_ctrl)
      OpSub, OpCmp: begin w_y = ~bus.b; w_cin = 1'b1; end
      OpRsb:        begin w_x = bus.b; w_y = ~bus.a; w_cin = 1'b1; end
      default:      ;
    endcase
  end

  assign w_sum = {1'b0, w_x} + {1'b0, w_y} + {{WIDTH{1'b0}}, w_cin};
  assign w_ovf = (w_x[WIDTH-1] == w_y[WIDTH-1]) && (w_sum[WIDTH-1] != w_x[WIDTH-1]);

  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    unique case (bus.alu_ctrl)
      OpAnd: w_res = bus.a & bus.b;
      OpXor: w_res = bus.a ^ bus.b;
      OpSub, OpRsb, OpAdd, OpCmp, OpCmn: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = w_ovf;
      end
      OpOrr: w_res = bus.a | bus.b;
      OpMov, OpLsl, OpLsr: w_res = bus.b;
      OpBic: w_res = bus.a & ~bus.b;
      OpMvn: w_res = ~bus.b;
      default: w_res = '0;
    endcase
  end

  always_comb begin
    w_state_d   = r_state;
    w_op_d      = r_op;
    w_fw_d      = r_fw;
    w_cond_ex_d = r_cond_ex;
    w_acc_d     = r_acc;
    w_cnt_d     = r_cnt;
    w_result_d  = r_result;
    w_flags_d   = r_flags;
    w_res_we_d  = 1'b0;
    if (r_state == StShift) begin
      if (r_cnt == SHAMT_W'(1)) begin
        w_result_d = w_shift_res;
        w_flags_d  = upd_flags(r_flags, w_shift_res[WIDTH-1], (w_shift_res == '0), 1'b0, 1'b0,
                               r_fw, r_cond_ex);
        w_res_we_d = r_cond_ex;
        w_cnt_d    = '0;
        w_state_d  = StDone;
      end else begin
        w_acc_d = w_shift_res;
        w_cnt_d = r_cnt - SHAMT_W'(1);
      end
    end else if (bus.start) begin
      w_op_d      = bus.alu_ctrl;
      w_fw_d      = bus.flag_w;
      w_cond_ex_d = w_cond_ex;
      if (w_is_shift) begin
        w_acc_d   = bus.b;
        w_cnt_d   = bus.shamt;
        w_state_d = StShift;
      end else begin
        w_result_d = w_res;
        w_flags_d  = upd_flags(r_flags, w_res[WIDTH-1], (w_res == '0), w_c, w_v,
                               bus.flag_w, w_cond_ex);
        w_res_we_d = w_cond_ex && (bus.alu_ctrl != OpCmp) && (bus.alu_ctrl != OpCmn);
        w_state_d  = StDone;
      end
    end else begin
      w_state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_op      <= '0;
      r_fw      <= '0;
      r_cond_ex <= 1'b0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_result  <= '0;
      r_flags   <= '0;
      r_res_we  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_op      <= w_op_d;
      r_fw      <= w_fw_d;
      r_cond_ex <= w_cond_ex_d;
      r_acc     <= w_acc_d;
      r_cnt     <= w_cnt_d;
      r_result  <= w_result_d;
      r_flags   <= w_flags_d;
      r_res_we  <= w_res_we_d;
    end
  end

  assign bus.busy   = (r_state == StShift);
  assign bus.done   = (r_state == StDone);
  assign bus.result = r_result;
  assign bus.res_we = r_res_we;
  assign bus.flags  = r_flags;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed-vector bench for alu_exec_unit with hand-computed expectations.
module tb_alu_exec_unit;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;
  int   cyc;

  alu_exec_unit_if #(.WIDTH(32), .SHAMT_W(5)) bus ();

  alu_exec_unit #(.WIDTH(32), .SHAMT_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Present a request for one cycle; returns at the negedge after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [1:0] fw, input logic [3:0] cnd,
                       input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
    bus.start    = 1'b1;
    bus.alu_ctrl = op;
    bus.flag_w   = fw;
    bus.cond     = cnd;
    bus.a        = a;
    bus.b        = b;
    bus.shamt    = sh;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    bus.start = 1'b0;
    bus.alu_ctrl = 4'h0;
    bus.flag_w = 2'b00;
    bus.cond = 4'hE;
    bus.a = '0;
    bus.b = '0;
    bus.shamt = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_flags", {28'd0, bus.flags}, 32'd0);
    chk("rst_res_we", {31'd0, bus.res_we}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD overflow into the sign bit
    issue(4'b0100, 2'b11, 4'hE, 32'h7FFF_FFFF, 32'h1, 5'd0);
    chk("add_done", {31'd0, bus.done}, 32'd1);
    chk("add_result", bus.result, 32'h8000_0000);
    chk("add_flags", {28'd0, bus.flags}, 32'b1001);
    chk("add_res_we", {31'd0, bus.res_we}, 32'd1);

    // SUB equal operands; back-to-back MOVs see the updated Z
    issue(4'b0010, 2'b11, 4'hE, 32'd5, 32'd5, 5'd0);
    chk("sub_result", bus.result, 32'd0);
    chk("sub_flags", {28'd0, bus.flags}, 32'b0110);
    chk("sub_done", {31'd0, bus.done}, 32'd1);
    issue(4'b1000, 2'b00, 4'h0, 32'd0, 32'h1234, 5'd0);
    chk("mov_eq_res_we", {31'd0, bus.res_we}, 32'd1);
    chk("mov_eq_result", bus.result, 32'h1234);
    issue(4'b1000, 2'b11, 4'h1, 32'd0, 32'h55, 5'd0);
    chk("mov_ne_res_we", {31'd0, bus.res_we}, 32'd0);
    chk("mov_ne_result", bus.result, 32'h55);
    chk("mov_ne_flags", {28'd0, bus.flags}, 32'b0110);

    // 0x80000000 - 1: no borrow, signed overflow -> flags 0011
    issue(4'b0010, 2'b11, 4'hE, 32'h8000_0000, 32'd1, 5'd0);
    chk("subv_result", bus.result, 32'h7FFF_FFFF);
    chk("subv_flags", {28'd0, bus.flags}, 32'b0011);

    // CMP 3-7 writing only N/Z
    issue(4'b0101, 2'b10, 4'hE, 32'd3, 32'd7, 5'd0);
    chk("cmp_res_we", {31'd0, bus.res_we}, 32'd0);
    chk("cmp_flags", {28'd0, bus.flags}, 32'b1011);
    chk("cmp_result", bus.result, 32'hFFFF_FFFC);

    // RSB 7-3 with GE condition (N=1,V=1 -> true)
    issue(4'b0011, 2'b11, 4'hA, 32'd3, 32'd7, 5'd0);
    chk("rsb_result", bus.result, 32'd4);
    chk("rsb_flags", {28'd0, bus.flags}, 32'b0010);

    // Zero-length shift completes in one cycle
    issue(4'b1010, 2'b11, 4'hE, 32'd0, 32'hF0, 5'd0);
    chk("lsr0_done", {31'd0, bus.done}, 32'd1);
    chk("lsr0_busy", {31'd0, bus.busy}, 32'd0);
    chk("lsr0_result", bus.result, 32'hF0);
    chk("lsr0_flags", {28'd0, bus.flags}, 32'b0000);

    // Undefined opcode gives zero
    issue(4'b1111, 2'b10, 4'hE, 32'd1, 32'd1, 5'd0);
    chk("op15_result", bus.result, 32'd0);
    chk("op15_flags", {28'd0, bus.flags}, 32'b0100);

    // LSL by 4 with an ignored request at cycle 2
    issue(4'b1001, 2'b11, 4'hE, 32'd0, 32'd1, 5'd4);
    chk("lsl_c1_busy", {31'd0, bus.busy}, 32'd1);
    chk("lsl_c1_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    bus.start = 1'b1;
    bus.alu_ctrl = 4'b1000;
    bus.b = 32'hDEAD;
    chk("lsl_c2_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    bus.start = 1'b0;
    chk("lsl_c3_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    chk("lsl_c4_busy", {31'd0, bus.busy}, 32'd1);
    chk("lsl_c4_done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    chk("lsl_c5_done", {31'd0, bus.done}, 32'd1);
    chk("lsl_c5_busy", {31'd0, bus.busy}, 32'd0);
    chk("lsl_c5_result", bus.result, 32'h10);
    chk("lsl_c5_flags", {28'd0, bus.flags}, 32'b0000);
    chk("lsl_c5_res_we", {31'd0, bus.res_we}, 32'd1);
    @(negedge clk);
    chk("lsl_c6_done", {31'd0, bus.done}, 32'd0);
    chk("lsl_c6_result", bus.result, 32'h10);

    // Asynchronous reset in the middle of a shift
    issue(4'b1000, 2'b11, 4'hE, 32'd0, 32'h8000_0000, 5'd0);
    chk("pre_rst_flags", {28'd0, bus.flags}, 32'b1000);
    issue(4'b1001, 2'b11, 4'hE, 32'd0, 32'd3, 5'd8);
    chk("mid_c1_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_done", {31'd0, bus.done}, 32'd0);
    chk("mid_rst_result", bus.result, 32'd0);
    chk("mid_rst_flags", {28'd0, bus.flags}, 32'd0);
    chk("mid_rst_res_we", {31'd0, bus.res_we}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue(4'b0100, 2'b11, 4'hE, 32'hFFFF_FFFF, 32'd2, 5'd0);
    chk("post_rst_done", {31'd0, bus.done}, 32'd1);
    chk("post_rst_result", bus.result, 32'd1);
    chk("post_rst_flags", {28'd0, bus.flags}, 32'b0010);

    // Longest right shift: done at cycle 32
    issue(4'b1010, 2'b11, 4'hE, 32'd0, 32'h8000_0000, 5'd31);
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("lsr31_cycles", cyc, 32'd32);
    chk("lsr31_result", bus.result, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
